// File: rtl/axi_mm_burst_checker_if.sv
// AXI4 memory-mapped read channels (AR + R) between the burst checker
// and the memory slave it exercises.
interface axi_mm_burst_checker_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize,
    output arburst, arlock, arcache, arprot,
    output arvalid, rready,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize,
    input  arburst, arlock, arcache, arprot,
    input  arvalid, rready,
    output arready,
    output rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_mm_burst_checker.sv
// AXI-MM read checker: turns byte commands into aligned INCR bursts and
// compares returned beats, masked to the requested bytes, to a golden stream.
module axi_mm_burst_checker #(
  parameter int          DATA_W          = 512,
  parameter int          ADDR_W          = 64,
  parameter int          ID_W            = 4,
  parameter int unsigned ARID_VAL        = 0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic              axis_clk,
  input  logic              axis_rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [15:0]       cmd_len,
  input  logic              gold_tvalid,
  output logic              gold_tready,
  input  logic [DATA_W-1:0] gold_tdata,
  axi_mm_burst_checker_if.master m_axi,
  input  logic              stat_clear,
  output logic              busy,
  output logic [31:0]       mismatch_cnt,
  output logic [31:0]       resp_err_cnt,
  output logic [31:0]       cmd_err_cnt,
  output logic [31:0]       first_mis_beat,
  output logic [31:0]       beat_cnt,
  output logic              passed
);
  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int PW = (MAX_OUTSTANDING > 1) ?
                      $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {AR_IDLE, AR_ISSUE} ar_state_t;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [OFF_W-1:0] lastb;
    logic [8:0]       beats;
  } info_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  ar_state_t         st, st_n;
  logic              ar_valid;
  logic [ADDR_W-1:0] ar_addr_q;
  logic [7:0]        ar_len_q;
  info_t             ar_info_q;
  logic [OW-1:0]     outst;
  info_t             fifo [2**PW];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [8:0]        bidx;
  logic              pv, p_mis, p_err;

  logic [OFF_W-1:0] c_off, c_lastb;
  logic [16:0]      c_total, c_beats;
  logic [17:0]      c_end;
  logic             c_bad, cmd_hs, ar_hs;

  assign c_off   = cmd_addr[OFF_W-1:0];
  assign c_total = {1'b0, cmd_len} + 17'(c_off);
  assign c_beats = (c_total + 17'(BYTES - 1)) >> OFF_W;
  assign c_end   = 18'(cmd_addr[11:0]) + 18'(cmd_len);
  assign c_lastb = c_off + OFF_W'(cmd_len) - OFF_W'(1);
  assign c_bad   = (cmd_len == 16'd0) ||
                   (c_beats > 17'd256) ||
                   (c_end > 18'd4096);
  assign cmd_hs  = cmd_valid && cmd_ready;
  assign ar_hs   = ar_valid && m_axi.arready;

  always_comb begin
    st_n      = st;
    cmd_ready = 1'b0;
    ar_valid  = 1'b0;
    unique case (st)
      AR_IDLE: begin
        cmd_ready = axis_rstn &&
                    (outst < OW'(MAX_OUTSTANDING));
        if (cmd_valid && cmd_ready && !c_bad)
          st_n = AR_ISSUE;
      end
      AR_ISSUE: begin
        ar_valid = axis_rstn;
        if (ar_valid && m_axi.arready)
          st_n = AR_IDLE;
      end
      default: st_n = AR_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) st <= AR_IDLE;
    else            st <= st_n;
  end

  assign m_axi.arid    = ID_W'(ARID_VAL);
  assign m_axi.araddr  = ar_addr_q;
  assign m_axi.arlen   = ar_len_q;
  assign m_axi.arsize  = 3'(OFF_W);
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arvalid = ar_valid;

  info_t head;
  logic  f_empty, r_hs, r_pop;
  logic  r_first, r_last, r_len_err;
  logic  r_err, r_mis;

  assign head        = fifo[rd_ptr];
  assign f_empty     = (outst == '0);
  assign m_axi.rready = axis_rstn && gold_tvalid && !f_empty;
  assign gold_tready = axis_rstn && m_axi.rvalid && !f_empty;
  assign r_hs        = m_axi.rvalid && m_axi.rready;
  assign r_pop       = r_hs && m_axi.rlast;
  assign r_first     = (bidx == 9'd0);
  assign r_last      = (bidx == head.beats - 9'd1);
  // Early rlast, or a missing one on the final beat, flags that beat.
  assign r_len_err   = m_axi.rlast ?
                       (bidx < head.beats - 9'd1) : r_last;
  assign r_err       = (m_axi.rresp != 2'b00) ||
                       (m_axi.rid != ID_W'(ARID_VAL)) ||
                       r_len_err;

  always_comb begin
    r_mis = 1'b0;
    for (int i = 0; i < BYTES; i++) begin
      if ((!r_first || i >= int'(head.off)) &&
          (!r_last || i <= int'(head.lastb)) &&
          (m_axi.rdata[8*i +: 8] != gold_tdata[8*i +: 8]))
        r_mis = 1'b1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (ar_hs) fifo[wr_ptr] <= ar_info_q;
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn) begin
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_info_q <= '0;
      outst     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      bidx      <= '0;
      pv        <= 1'b0;
      p_mis     <= 1'b0;
      p_err     <= 1'b0;
    end else begin
      if (cmd_hs && !c_bad) begin
        ar_addr_q <= {cmd_addr[ADDR_W-1:OFF_W],
                      {OFF_W{1'b0}}};
        ar_len_q  <= c_beats[7:0] - 8'd1;
        ar_info_q <= '{off: c_off, lastb: c_lastb,
                       beats: c_beats[8:0]};
      end
      if (ar_hs) wr_ptr <= wr_ptr + PW'(1);
      unique case ({ar_hs, r_pop})
        2'b10:   outst <= outst + OW'(1);
        2'b01:   outst <= outst - OW'(1);
        default: outst <= outst;
      endcase
      if (r_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        bidx   <= '0;
      end else if (r_hs && bidx != '1) begin
        bidx <= bidx + 9'd1;
      end
      pv    <= r_hs;
      p_mis <= r_hs && r_mis;
      p_err <= r_hs && r_err;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (!axis_rstn || stat_clear) begin
      mismatch_cnt   <= '0;
      resp_err_cnt   <= '0;
      cmd_err_cnt    <= '0;
      first_mis_beat <= '0;
      beat_cnt       <= '0;
    end else begin
      if (cmd_hs && c_bad)
        cmd_err_cnt <= sat_inc(cmd_err_cnt);
      if (pv) beat_cnt <= sat_inc(beat_cnt);
      if (p_mis) begin
        mismatch_cnt <= sat_inc(mismatch_cnt);
        if (mismatch_cnt == 32'd0)
          first_mis_beat <= beat_cnt;
      end
      if (p_err)
        resp_err_cnt <= sat_inc(resp_err_cnt);
    end
  end

  assign busy   = (st != AR_IDLE) || !f_empty || pv;
  assign passed = !busy && (beat_cnt != 32'd0) &&
                  (mismatch_cnt == 32'd0) &&
                  (resp_err_cnt == 32'd0) &&
                  (cmd_err_cnt == 32'd0);
endmodule
